uart_tx_fifo: RTL and testbench

Parametrised, buffered UART transmitter for the motor-control telemetry path. It accepts words through a valid/ready handshake into an internal FIFO. It serialises each word as an asynchronous frame with these options:
- runtime baud divisor
- configurable data width
- optional parity
- 1 or 2 stop bits

It sits between the telemetry formatter and the board TX pin. It replaces fixed-format, unbuffered transmission.

---
 rtl/uart_tx_fifo.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready FIFO feeding a framed serialiser.
// Define UART_TX_PARITY_EN to compile in the parity bit and parity_mode decode.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic [1:0]                    parity_mode,
    input  logic                          two_stop,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int BCW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP1,
        S_STOP2
    } state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        level;
    logic [DATA_BITS-1:0] head;

    state_t               state, state_n;
    logic [DIV_W-1:0]     cyc_cnt;
    logic [DIV_W-1:0]     div_q;
    logic [BCW-1:0]       bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 two_stop_q;
    logic                 tx_q, tx_n;
    logic                 push, pop, bit_done, last_bit;

`ifdef UART_TX_PARITY_EN
    logic                 par_en_q, par_bit_q;
`else
    logic                 unused_parity;
    assign unused_parity = ^parity_mode;
`endif

    assign in_ready   = (level != LW'(FIFO_DEPTH));
    assign push       = in_valid && in_ready;
    assign pop        = (state == S_IDLE) && (level != '0);
    assign head       = mem[rd_ptr];
    assign bit_done   = (cyc_cnt == div_q - DIV_W'(1));
    assign last_bit   = (bit_cnt == BCW'(DATA_BITS - 1));
    assign fifo_level = level;
    assign busy       = (state != S_IDLE) || (level != '0);
    assign tx         = tx_q;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        tx_n    = 1'b1;
        unique case (state)
            S_IDLE: begin
                if (pop) state_n = S_START;
            end
            S_START: begin
                tx_n = 1'b0;
                if (bit_done) state_n = S_DATA;
            end
            S_DATA: begin
                tx_n = shreg[0];
                if (bit_done && last_bit) begin
`ifdef UART_TX_PARITY_EN
                    state_n = par_en_q ? S_PARITY : S_STOP1;
`else
                    state_n = S_STOP1;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                tx_n = par_bit_q;
                if (bit_done) state_n = S_STOP1;
            end
`endif
            S_STOP1: begin
                if (bit_done) state_n = two_stop_q ? S_STOP2 : S_IDLE;
            end
            S_STOP2: begin
                if (bit_done) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // tx is registered from the current state, so the line lags state by a cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            tx_q       <= 1'b1;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            div_q      <= DIV_W'(2);
            two_stop_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
        end else begin
            state <= state_n;
            tx_q  <= tx_n;
            if (pop) begin
                shreg      <= head;
                div_q      <= (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
                two_stop_q <= two_stop;
                cyc_cnt    <= '0;
                bit_cnt    <= '0;
`ifdef UART_TX_PARITY_EN
                par_en_q   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                par_bit_q  <= (^head) ^ parity_mode[1];
`endif
            end else if (state != S_IDLE) begin
                if (bit_done) begin
                    cyc_cnt <= '0;
                    if (state == S_DATA) begin
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + BCW'(1);
                    end
                end else begin
                    cyc_cnt <= cyc_cnt + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (DATA_BITS=8, FIFO_DEPTH=4).
// Parity expectations follow whether UART_TX_PARITY_EN is defined.
module tb_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] baud_div = 16'd4;
    logic [1:0]  parity_mode = 2'b00;
    logic        two_stop = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        tx;
    logic        busy;
    logic [2:0]  fifo_level;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .DIV_W(16)) dut (
        .clk(clk), .rst(rst), .baud_div(baud_div),
        .parity_mode(parity_mode), .two_stop(two_stop),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .tx(tx), .busy(busy), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Waits for the start bit, then checks the line level on every frame cycle
    task automatic recv(input logic [7:0] d, input int div, input bit pe,
                        input bit pb, input int nstop, input int chg_at,
                        input int chg_div, output int waited);
        logic [15:0] fb;
        int nb;
        int c;
        fb = '1;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[1+i] = d[i];
        nb = 9;
        if (pe) begin
            fb[nb] = pb;
            nb++;
        end
        nb = nb + nstop;
        waited = 0;
        while (tx !== 1'b0 && waited < 2000) begin
            tick();
            waited++;
        end
        chk("start_timeout", 32'(waited < 2000), 32'd1);
        c = 0;
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < div; k++) begin
                if (c == chg_at) baud_div = 16'(chg_div);
                chk($sformatf("frame_%0h_bit%0d_cyc%0d", d, b, k), 32'(tx), 32'(fb[b]));
                tick();
                c++;
            end
        end
    endtask

    initial begin
        int w;
        int lows;

        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ready", 32'(in_ready), 32'd1);
        chk("reset_level", 32'(fifo_level), 32'd0);

        // basic 8N1 frame, latency 2 edges from accept to tx fall
        push(8'h55);
        chk("basic_busy_rise", 32'(busy), 32'd1);
        chk("basic_level1", 32'(fifo_level), 32'd1);
        chk("basic_tx_idle", 32'(tx), 32'd1);
        recv(8'h55, 4, 1'b0, 1'b0, 1, -1, 0, w);
        chk("basic_latency", 32'(w), 32'd2);
        chk("basic_busy_fall", 32'(busy), 32'd0);
        chk("basic_level0", 32'(fifo_level), 32'd0);
        chk("basic_tx_after", 32'(tx), 32'd1);

        parity_mode = 2'b01;
        push(8'h07);
        recv(8'h07, 4, PAR, 1'b1, 1, -1, 0, w);
        chk("even_busy_fall", 32'(busy), 32'd0);

        parity_mode = 2'b10;
        push(8'h00);
        recv(8'h00, 4, PAR, 1'b1, 1, -1, 0, w);
        chk("odd_tx_after", 32'(tx), 32'd1);

        parity_mode = 2'b11;
        push(8'h80);
        recv(8'h80, 4, 1'b0, 1'b0, 1, -1, 0, w);
        parity_mode = 2'b00;

        // config latched at pop: change divisor during DATA bit 1
        baud_div = 16'd4;
        two_stop = 1'b1;
        push(8'h3C);
        push(8'hC3);
        recv(8'h3C, 4, 1'b0, 1'b0, 2, 10, 8, w);
        recv(8'hC3, 8, 1'b0, 1'b0, 2, -1, 0, w);
        chk("latch_gap", 32'(w), 32'd1);
        chk("latch_busy_fall", 32'(busy), 32'd0);
        two_stop = 1'b0;

        baud_div = 16'd0;
        push(8'h96);
        recv(8'h96, 2, 1'b0, 1'b0, 1, -1, 0, w);
        chk("clamp0_latency", 32'(w), 32'd2);
        baud_div = 16'd1;
        push(8'h69);
        recv(8'h69, 2, 1'b0, 1'b0, 1, -1, 0, w);
        chk("clamp1_latency", 32'(w), 32'd2);

        // FIFO full with back-to-back frames
        baud_div = 16'd4;
        fork
            begin
                int fw;
                for (int f = 1; f <= 6; f++) begin
                    recv(8'(f), 4, 1'b0, 1'b0, 1, -1, 0, fw);
                    if (f > 1) chk($sformatf("b2b_gap_%0d", f), 32'(fw), 32'd1);
                end
            end
            begin
                int pw;
                for (int k = 1; k <= 5; k++) begin
                    if (k == 5) chk("full_ready_before", 32'(in_ready), 32'd1);
                    in_data  = 8'(k);
                    in_valid = 1'b1;
                    tick();
                end
                chk("full_ready_low", 32'(in_ready), 32'd0);
                chk("full_level4", 32'(fifo_level), 32'd4);
                in_data = 8'h06;
                pw = 0;
                while (!in_ready && pw < 500) begin
                    tick();
                    pw++;
                end
                chk("full_ready_reopen", 32'(in_ready), 32'd1);
                tick();
                in_valid = 1'b0;
                chk("full_level_after6", 32'(fifo_level), 32'd4);
            end
        join
        chk("full_busy_fall", 32'(busy), 32'd0);
        chk("full_level_end", 32'(fifo_level), 32'd0);

        // reset during data bit 3 of 0xA5 with two words queued
        push(8'hA5);
        push(8'h11);
        push(8'h22);
        chk("rst_queued", 32'(fifo_level), 32'd2);
        chk("rst_start_bit", 32'(tx), 32'd0);
        repeat (17) tick();
        chk("rst_mid_bit3", 32'(tx), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_async_tx", 32'(tx), 32'd1);
        chk("rst_async_level", 32'(fifo_level), 32'd0);
        chk("rst_async_busy", 32'(busy), 32'd0);
        chk("rst_async_ready", 32'(in_ready), 32'd1);
        tick();
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        chk("rst_line_quiet", 32'(lows), 32'd0);
        chk("rst_level_after", 32'(fifo_level), 32'd0);
        chk("rst_busy_after", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
